// File: rtl/deserializer_rx.sv
// Serial-to-parallel receiver for the st/tx link: skips the transmitter load cycle, shifts WIDTH
// bits LSB-first and presents completed words on a registered valid/ready port.
module deserializer_rx #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st,
    input  logic             rx,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             abort,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StWait, StShift} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] word;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             abort_q, abort_d;
    logic             busy_q, busy_d;
    logic             complete;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        abort_d   = 1'b0;
        complete  = 1'b0;
        // Completed word includes the bit being sampled on this same edge.
        word             = sr_q;
        word[WIDTH-1]    = rx;

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (st) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (st) begin
                    state_d = StShift;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                if (!st) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    sr_d    = '0;
                    abort_d = 1'b1;
                end else begin
                    sr_d[cnt_q] = rx;
                    if (cnt_q == LAST) begin
                        complete = 1'b1;
                        cnt_d    = '0;
                        state_d  = StWait;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (complete) begin
            if (!valid_q || out_ready) begin
                data_d  = word;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sr_q      <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            abort_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            abort_q   <= abort_d;
            busy_q    <= busy_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;
    assign abort     = abort_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_deserializer_rx.sv
// Scoreboard bench for deserializer_rx: frame-position model predicts words, pulses and busy;
// a negedge monitor pops expected words on every handshake.
module tb_deserializer_rx;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         st;
    logic         rx;
    logic [W-1:0] data_out;
    logic         out_valid;
    logic         out_ready;
    logic         overrun;
    logic         abort;
    logic         busy;

    deserializer_rx #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .st       (st),
        .rx       (rx),
        .data_out (data_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun  (overrun),
        .abort    (abort),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] exp_q[$];
    int           run_k = 0;   // consecutive st-high edges since leaving idle
    logic         held  = 1'b0;
    logic [W-1:0] mword = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer happens on the coming edge whenever valid and ready are both high now.
    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {28'd0, data_out}, 32'hdead);
            end else begin
                check("word", {28'd0, data_out}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    // One clock edge: drive inputs, advance the model, then check flags shortly after the edge.
    task automatic cyc(input logic s, input logic r, input logic q);
        int   pos;
        logic ab, ov, xfer, complete;
        st        = s;
        rx        = r;
        out_ready = q;
        @(posedge clk);
        xfer     = held && q;
        ab       = 1'b0;
        ov       = 1'b0;
        complete = 1'b0;
        if (s) begin
            run_k++;
            if (run_k >= 2) begin
                // Period W+1 after the first load cycle: position 0 is load, 1..W are bits.
                pos = (run_k - 2) % (W + 1);
                if (pos >= 1) begin
                    mword[pos-1] = r;
                    complete     = (pos == W);
                end
            end
        end else begin
            if (run_k >= 2 && ((run_k - 2) % (W + 1)) != W) ab = 1'b1;
            run_k = 0;
        end
        if (complete) begin
            if (!held || q) begin
                exp_q.push_back(mword);
                held = 1'b1;
            end else begin
                ov = 1'b1;
            end
        end else if (xfer) begin
            held = 1'b0;
        end
        #2;
        check("out_valid", {31'd0, out_valid}, {31'd0, held});
        check("overrun", {31'd0, overrun}, {31'd0, ov});
        check("abort", {31'd0, abort}, {31'd0, ab});
        check("busy", {31'd0, busy}, {31'd0, run_k > 0});
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        st        = 1'b1;
        rx        = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        run_k = 0;
        held  = 1'b0;
        exp_q.delete();
        #2;
        check("rst_data_out", {28'd0, data_out}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_abort", {31'd0, abort}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
    endtask

    // Leading st-high edges (idle->load, load->shift) with junk on rx.
    task automatic start(input logic q);
        cyc(1'b1, 1'($urandom), q);
        cyc(1'b1, 1'($urandom), q);
    endtask

    task automatic bits(input logic [W-1:0] w, input logic q);
        for (int i = 0; i < W; i++) cyc(1'b1, w[i], q);
    endtask

    initial begin
        reset     = 1'b0;
        st        = 1'b0;
        rx        = 1'b0;
        out_ready = 1'b0;
        do_reset();
        do_reset();
        cyc(1'b0, 1'b1, 1'b1);

        // Single word 1101, accepted next cycle.
        start(1'b1);
        bits(4'b1101, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);

        // Back-to-back A then 3.
        start(1'b1);
        bits(4'hA, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        bits(4'h3, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);

        // Back-pressure: 5 held, 9 dropped with overrun.
        start(1'b0);
        bits(4'h5, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        bits(4'h9, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("held_5", {28'd0, data_out}, 32'h5);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);

        // Accept of 5 on the same edge that completes 9.
        start(1'b0);
        bits(4'h5, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < W - 1; i++) cyc(1'b1, 1'(4'h9 >> i), 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        check("simul_9", {28'd0, data_out}, 32'h9);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);

        // Abort after two bits while a word is held, then a clean frame C.
        start(1'b0);
        bits(4'hE, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        check("abort_keeps_E", {28'd0, data_out}, 32'hE);
        cyc(1'b0, 1'b0, 1'b1);
        start(1'b1);
        bits(4'hC, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);

        // Glitch in the load cycle restarts the frame.
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        start(1'b1);
        bits(4'h6, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);

        // Reset mid-shift with a word held, then fresh frame 7.
        start(1'b0);
        bits(4'hB, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        start(1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        do_reset();
        start(1'b1);
        bits(4'h7, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);

        // Random traffic with random back-pressure and st drops.
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 15) != 0), 1'($urandom), 1'($urandom));
        end

        // Drain.
        for (int n = 0; n < 4; n++) cyc(1'b0, 1'b0, 1'b1);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
